// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for DIV / DIVU. Sits in EX beside
//   the ALU. It writes {remainder, quotient} for the HI/LO register file and
//   holds the pipeline through `stall` while it iterates.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request a divide; operands are sampled in the same cycle
//   signed_div  1 = DIV (signed), 0 = DIVU; sampled with start
//   annul       cancel the operation in flight (exception / flush)
//   num1        dividend (rs)
//   num2        divisor  (rt)
//   result      {remainder, quotient}; valid while ready = 1, then held
//   ready       one-cycle result-valid strobe
//   stall       combinational pipeline hold request
// ----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DIVZERO,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder (always < divisor)
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]     dvs_q, dvs_d;      // divisor magnitude
    logic                 qneg_q, qneg_d;    // quotient must be negated at the end
    logic                 rneg_q, rneg_d;    // remainder must be negated at the end
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Datapath for one restoring step.
    logic [WIDTH:0]       rem_shift;
    logic                 fits;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic [WIDTH-1:0]     abs_num1;
    logic [WIDTH-1:0]     abs_num2;
    logic                 sign1;
    logic                 sign2;

    always_comb begin
        sign1    = signed_div & num1[WIDTH-1];
        sign2    = signed_div & num2[WIDTH-1];
        abs_num1 = sign1 ? -num1 : num1;
        abs_num2 = sign2 ? -num2 : num2;

        // (WIDTH+1)-bit partial remainder: previous remainder with the next
        // dividend bit shifted in.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        // When the divisor fits, the true difference is below 2^WIDTH, so the
        // modular WIDTH-bit subtraction yields exactly that difference.
        rem_next  = fits ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
        quo_next  = (quo_q << 1) | WIDTH'(fits);

        // Sign fix-up applied on the final step. The most-negative / -1 case
        // wraps naturally: magnitude 2^(WIDTH-1) negates to itself.
        q_fix = qneg_q ? -quo_next : quo_next;
        r_fix = rneg_q ? -rem_next : rem_next;
    end

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        stall    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    stall = 1'b1;
                    if (num2 == '0) begin
                        // Remember the raw dividend; it becomes the remainder.
                        quo_d   = num1;
                        state_d = DIVZERO;
                    end else begin
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = abs_num1;
                        dvs_d   = abs_num2;
                        qneg_d  = sign1 ^ sign2;
                        rneg_d  = sign1;
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                stall = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_next;
                    quo_d   = quo_next;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_d = {r_fix, q_fix};
                        state_d  = DONE;
                    end
                end
            end

            DIVZERO: begin
                stall = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    result_d = {quo_q, {WIDTH{1'b1}}};
                    state_d  = DONE;
                end
            end

            DONE: begin
                // Result is already registered; release the pipeline now.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = (state_q == DONE);

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboarded bench for div_unit (WIDTH = 32). The driver pushes the
//   expected {remainder, quotient} and the cycle in which ready must appear;
//   a monitor pops and compares whenever ready is seen. Expected values come
//   from plain integer division with the divide-by-zero and overflow rules.
// ----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic           annul;
    logic [W-1:0]   num1;
    logic [W-1:0]   num2;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .num1       (num1),
        .num2       (num2),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Cycle index; constant between a rising edge and the next one.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] res;
        int             due;
    } exp_t;

    exp_t           sb_q[$];
    int             tests = 0;
    int             fails = 0;
    logic [2*W-1:0] last_res = '0;

    task automatic check(input string name, input logic [2*W-1:0] actual,
                         input logic [2*W-1:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: integer division with truncation toward zero, plus the
    // divide-by-zero and most-negative / -1 rules.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic sgn);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           sa;
        int           sb;
        if (b == 0) return {a, {W{1'b1}}};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'h0, 32'h8000_0000};
            sa = int'(a);
            sb = int'(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Monitor: any ready must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("ready_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one divide, scramble operands while it runs, count stall cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        int   lat;
        int   stalls;
        bit   seen;
        exp_t e;
        lat = (b == 0) ? 2 : W + 1;
        @(negedge clk);
        num1 = a; num2 = b; signed_div = sgn; start = 1'b1;
        e.res = model(a, b, sgn);
        e.due = cyc + lat;
        sb_q.push_back(e);
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (ready) begin
                seen = 1'b1;
                check("stall_in_ready_cycle", 64'(stall), 64'd0);
                break;
            end
            if (stall) stalls++;
            @(negedge clk);
            start = 1'b0;
            num1  = $urandom;
            num2  = $urandom;
            signed_div = 1'($urandom_range(0, 1));
        end
        check("ready_seen", 64'(seen), 64'd1);
        check("stall_cycles", 64'(stalls), 64'(lat));
        last_res = e.res;
        @(negedge clk);
    endtask

    // Start a divide and annul it in cycle n after the start cycle.
    task automatic annul_op(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        @(negedge clk);
        num1 = a; num2 = b; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (n - 1) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("annul_stall", 64'(stall), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result_held", result, last_res);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        num1 = '0; num2 = '0;
        #3;
        check("reset_result", result, 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFF9, 32'h2, 1'b1);
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h0000_1234, 32'h0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'h0, 1'b1);

        annul_op(32'd1000, 32'd3, 10);
        run_op(32'd1000, 32'd3, 1'b0);
        annul_op(32'h55, 32'h0, 1);

        // start together with annul in IDLE is dropped.
        @(negedge clk);
        num1 = 32'd9; num2 = 32'd2; start = 1'b1; annul = 1'b1;
        #1;
        check("start_annul_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset in BUSY cycle 5, between clock edges.
        @(negedge clk);
        num1 = 32'd500; num2 = 32'd9; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", result, 64'd0);
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_stall", 64'(stall), 64'd0);
        #1 rst = 1'b0;
        last_res = '0;
        repeat (40) @(negedge clk);
        run_op(32'd100, 32'd7, 1'b0);

        // Randomized mix of signed/unsigned, with zero, one and edge values.
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           sel;
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(2, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
